// File: rtl/fft_burst_buf.sv
// Burst capture buffer: skips pipeline-flush samples, stores one 2^N_LOG2 frame in a
// single-port RAM, tracks the frame's saturated peak |x| and replays it as a valid/ready stream.
module fft_burst_buf #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 12,
    parameter int SKIP   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          sample_en,
    input  logic          start,
    input  logic          abort,
    output logic [DW-1:0] fft_data,
    output logic          fft_valid,
    input  logic          fft_ready,
    output logic          fft_last,
    output logic [DW-2:0] peak_abs,
    output logic          busy,
    output logic          done
);

    localparam int                     N         = 1 << N_LOG2;
    localparam int                     SKW       = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKW-1:0]         SKIP_LAST = (SKIP > 0) ? SKW'(SKIP - 1) : '0;
    localparam logic signed [DW-1:0]   MOST_NEG  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, READOUT} state_t;

    state_t                state_q, state_d;
    logic [SKW-1:0]        skip_cnt_q, skip_cnt_d;
    logic [N_LOG2-1:0]     wr_addr_q, wr_addr_d;
    logic [N_LOG2:0]       rd_addr_q, rd_addr_d;
    logic [DW-2:0]         peak_run_q, peak_run_d;
    logic [DW-2:0]         peak_abs_q, peak_abs_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_last_q, ram_last_d;
    logic signed [DW-1:0]  ram_data_q;
    logic signed [DW-1:0]  fft_data_q, fft_data_d;
    logic                  fft_valid_q, fft_valid_d;
    logic                  fft_last_q, fft_last_d;

    logic signed [DW-1:0]  mem [N];
    logic                  wr_en, rd_en, out_adv, last_xfer;
    logic [DW-2:0]         sample_abs, peak_next;

    // |x| in DW bits; the most negative code has no positive twin and saturates
    function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] s);
        logic signed [DW-1:0] neg;
        neg = -s;
        if (s == MOST_NEG)
            abs_sat = '1;
        else if (s[DW-1])
            abs_sat = neg[DW-2:0];
        else
            abs_sat = s[DW-2:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        peak_run_d  = peak_run_q;
        peak_abs_d  = peak_abs_q;
        ram_vld_d   = ram_vld_q;
        ram_last_d  = ram_last_q;
        fft_data_d  = fft_data_q;
        fft_valid_d = fft_valid_q;
        fft_last_d  = fft_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        sample_abs = abs_sat($signed(data_in));
        peak_next  = (sample_abs > peak_run_q) ? sample_abs : peak_run_q;
        out_adv    = !fft_valid_q || fft_ready;
        last_xfer  = fft_valid_q && fft_ready && fft_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    skip_cnt_d = '0;
                    peak_run_d = '0;
                    wr_addr_d  = '0;
                    state_d    = (SKIP == 0) ? CAPTURE : ARM;
                end
            end
            ARM: begin
                if (sample_en) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        skip_cnt_d = '0;
                        peak_run_d = '0;
                        state_d    = CAPTURE;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (sample_en) begin
                    wr_en      = 1'b1;
                    wr_addr_d  = wr_addr_q + 1'b1;
                    peak_run_d = peak_next;
                    if (&wr_addr_q) begin
                        peak_abs_d = peak_next;
                        rd_addr_d  = '0;
                        state_d    = READOUT;
                    end
                end
            end
            READOUT: begin
                // RAM output register doubles as the prefetch stage: it only
                // reloads once its current word has moved into the output register
                rd_en = !rd_addr_q[N_LOG2] && (!ram_vld_q || out_adv);
                if (rd_en) begin
                    rd_addr_d  = rd_addr_q + 1'b1;
                    ram_vld_d  = 1'b1;
                    ram_last_d = &rd_addr_q[N_LOG2-1:0];
                end else if (ram_vld_q && out_adv) begin
                    ram_vld_d  = 1'b0;
                    ram_last_d = 1'b0;
                end
                if (out_adv) begin
                    fft_valid_d = ram_vld_q;
                    fft_last_d  = ram_vld_q && ram_last_q;
                    if (ram_vld_q)
                        fft_data_d = ram_data_q;
                end
                if (last_xfer) begin
                    fft_valid_d = 1'b0;
                    fft_last_d  = 1'b0;
                    rd_addr_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            skip_cnt_d  = '0;
            wr_addr_d   = '0;
            rd_addr_d   = '0;
            peak_run_d  = '0;
            peak_abs_d  = peak_abs_q;
            ram_vld_d   = 1'b0;
            ram_last_d  = 1'b0;
            fft_valid_d = 1'b0;
            fft_last_d  = 1'b0;
            wr_en       = 1'b0;
            rd_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skip_cnt_q  <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            peak_run_q  <= '0;
            peak_abs_q  <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            fft_data_q  <= '0;
            fft_valid_q <= 1'b0;
            fft_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            peak_run_q  <= peak_run_d;
            peak_abs_q  <= peak_abs_d;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            fft_data_q  <= fft_data_d;
            fft_valid_q <= fft_valid_d;
            fft_last_q  <= fft_last_d;
        end
    end

    // Frame storage: no reset, every word is rewritten before it is read
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr_q] <= $signed(data_in);
        if (rd_en)
            ram_data_q <= mem[rd_addr_q[N_LOG2-1:0]];
    end

    assign fft_data  = fft_data_q;
    assign fft_valid = fft_valid_q;
    assign fft_last  = fft_last_q;
    assign peak_abs  = peak_abs_q;
    assign busy      = (state_q != IDLE);
    assign done      = last_xfer && !abort;

endmodule

// File: tb/tb_fft_burst_buf.sv
// Self-checking bench for fft_burst_buf: frame-level vector table, randomized frames
// against a queue/array reference model, plus abort, ignored-input and reset sequences.
module tb_fft_burst_buf;

    localparam int N_LOG2 = 10;
    localparam int DW     = 12;
    localparam int SKIP   = 2;
    localparam int N      = 1 << N_LOG2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          sample_en;
    logic          start;
    logic          abort;
    logic [DW-1:0] fft_data;
    logic          fft_valid;
    logic          fft_ready;
    logic          fft_last;
    logic [DW-2:0] peak_abs;
    logic          busy;
    logic          done;

    fft_burst_buf #(.N_LOG2(N_LOG2), .DW(DW), .SKIP(SKIP)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sample_en(sample_en),
        .start(start), .abort(abort), .fft_data(fft_data), .fft_valid(fft_valid),
        .fft_ready(fft_ready), .fft_last(fft_last), .peak_abs(peak_abs),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int prev_peak = 0;
    int stim [N + SKIP];

    typedef struct {
        int pat;        // 0: index ramp, 1: small random with specials
        int sp0, sp1, sp2;
        int ready_mode; // 0: always ready, 1: random ready
        int gap_pct;    // percentage of cycles without sample_en
        int exp_peak;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_abs(input int v);
        if (v == -2048) return 2047;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_peak();
        int m = 0;
        for (int i = 0; i < N; i++)
            if (ref_abs(stim[SKIP + i]) > m) m = ref_abs(stim[SKIP + i]);
        return m;
    endfunction

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic build_stim(input vec_t v);
        for (int k = 0; k < N + SKIP; k++) begin
            if (v.pat == 0)
                stim[k] = k % 2048;
            else
                stim[k] = (k < SKIP) ? -2048 : int'($urandom_range(0, 400)) - 200;
        end
        if (v.pat == 1) begin
            stim[SKIP + 100]  = v.sp0;
            stim[SKIP + 600]  = v.sp1;
            stim[SKIP + 1023] = v.sp2;
        end
    endtask

    // One complete burst; rst_at >= 0 pulls rst_n low after that many transfers
    task automatic run_frame(input int ready_mode, input int gap_pct,
                             input int exp_peak, input int rst_at);
        int k, cyc, idx;
        bit en, stalled;
        int hold_data, hold_last;
        int exp_q[$];

        exp_q = {};
        for (int i = 0; i < N; i++) exp_q.push_back(stim[SKIP + i] & 32'hFFF);

        start = 1'b1; sample_en = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_before_start", busy, 0);
        cyc_end();
        start = 1'b0;

        k = 0;
        while (k < N + SKIP) begin
            en        = ($urandom_range(0, 99) >= gap_pct);
            sample_en = en;
            data_in   = en ? DW'(stim[k]) : DW'($urandom);
            start     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            check("busy_capture", busy, 1);
            check("peak_held_capture", peak_abs, prev_peak);
            check("valid_capture", fft_valid, 0);
            cyc_end();
            if (en) k++;
        end

        cyc = 0; idx = 0; stalled = 0; hold_data = 0; hold_last = 0;
        while (idx < N && cyc < 40 * N) begin
            fft_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            sample_en = 1'($urandom_range(0, 1));
            data_in   = DW'($urandom);
            start     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            if (cyc == 0) begin
                check("peak_after_capture", peak_abs, exp_peak);
                prev_peak = exp_peak;
            end
            if (cyc < 2)  check("valid_too_early", fft_valid, 0);
            if (cyc == 2) check("valid_at_cycle2", fft_valid, 1);
            check("busy_readout", busy, 1);
            if (stalled) begin
                check("stall_valid", fft_valid, 1);
                check("stall_data", fft_data, hold_data);
                check("stall_last", fft_last, hold_last);
            end
            if (fft_valid && fft_ready) begin
                check("data", fft_data, exp_q[idx]);
                check("last", fft_last, (idx == N - 1) ? 1 : 0);
                check("done", done, (idx == N - 1) ? 1 : 0);
                idx++;
                stalled = 0;
            end else begin
                check("done_idle", done, 0);
                stalled   = fft_valid;
                hold_data = fft_data;
                hold_last = fft_last;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_fft_data", fft_data, 0);
                check("rst_fft_valid", fft_valid, 0);
                check("rst_fft_last", fft_last, 0);
                check("rst_peak", peak_abs, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                prev_peak = 0;
                cyc_end();
                rst_n = 1'b1;
                start = 1'b0; sample_en = 1'b0;
                cyc_end();
                return;
            end
            cyc_end();
            cyc++;
        end
        if (idx < N) check("readout_timeout", idx, N);

        start = 1'b0; sample_en = 1'b0;
        @(negedge clk);
        check("valid_after_frame", fft_valid, 0);
        check("last_after_frame", fft_last, 0);
        check("busy_after_frame", busy, 0);
        check("done_after_frame", done, 0);
        cyc_end();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{pat: 0, sp0: 0,    sp1: 0,     sp2: 0,     ready_mode: 0, gap_pct: 0,  exp_peak: 1025};
        vecs[1] = '{pat: 0, sp0: 0,    sp1: 0,     sp2: 0,     ready_mode: 1, gap_pct: 30, exp_peak: 1025};
        vecs[2] = '{pat: 1, sp0: 1500, sp1: -1998, sp2: -2048, ready_mode: 1, gap_pct: 10, exp_peak: 2047};
        vecs[3] = '{pat: 1, sp0: 300,  sp1: -300,  sp2: 17,    ready_mode: 0, gap_pct: 20, exp_peak: 300};
        vecs[4] = '{pat: 1, sp0: -1998, sp1: 5,    sp2: 0,     ready_mode: 1, gap_pct: 0,  exp_peak: 1998};
        vecs[5] = '{pat: 1, sp0: 2047, sp1: -2047, sp2: 0,     ready_mode: 0, gap_pct: 40, exp_peak: 2047};

        rst_n = 1'b0; data_in = '0; sample_en = 1'b0; start = 1'b0;
        abort = 1'b0; fft_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_fft_data", fft_data, 0);
        check("reset_fft_valid", fft_valid, 0);
        check("reset_fft_last", fft_last, 0);
        check("reset_peak", peak_abs, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        cyc_end();

        // abort and start together in IDLE: abort wins
        abort = 1'b1; start = 1'b1;
        cyc_end();
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1; data_in = DW'(i);
            @(negedge clk);
            check("abort_start_idle_busy", busy, 0);
            cyc_end();
        end
        sample_en = 1'b0;

        for (int v = 0; v < 6; v++) begin
            build_stim(vecs[v]);
            run_frame(vecs[v].ready_mode, vecs[v].gap_pct, vecs[v].exp_peak, -1);
        end

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N + SKIP; k++)
                stim[k] = int'($urandom_range(0, 4095)) - 2048;
            run_frame(1, 20, model_peak(), -1);
        end

        // abort while capture sample 500 is being written
        for (int k = 0; k < N + SKIP; k++) stim[k] = int'($urandom_range(0, 1000)) - 500;
        start = 1'b1;
        cyc_end();
        start = 1'b0;
        for (int k = 0; k < SKIP + 500; k++) begin
            sample_en = 1'b1; data_in = DW'(stim[k]);
            cyc_end();
        end
        sample_en = 1'b1; data_in = DW'(stim[SKIP + 500]); abort = 1'b1;
        cyc_end();
        abort = 1'b0; sample_en = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", fft_valid, 0);
        check("abort_done", done, 0);
        check("abort_peak", peak_abs, prev_peak);
        cyc_end();
        for (int i = 0; i < 8; i++) begin
            sample_en = 1'b1; data_in = DW'($urandom);
            @(negedge clk);
            check("post_abort_busy", busy, 0);
            check("post_abort_done", done, 0);
            cyc_end();
        end
        sample_en = 1'b0;
        for (int k = 0; k < N + SKIP; k++) stim[k] = int'($urandom_range(0, 800)) - 400;
        run_frame(0, 15, model_peak(), -1);

        // reset mid-readout, then a full burst
        for (int k = 0; k < N + SKIP; k++) stim[k] = int'($urandom_range(0, 4095)) - 2048;
        run_frame(1, 0, model_peak(), 300);
        for (int k = 0; k < N + SKIP; k++) stim[k] = int'($urandom_range(0, 4095)) - 2048;
        run_frame(1, 25, model_peak(), -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_burst_buf.md
Name: fft_burst_buf

Overview:
- Sits directly downstream of the sample-conversion stage that emits 12-bit two's-complement samples every clock.
- Captures one burst of 2^N_LOG2 samples, qualified by sample_en, into an internal single-port RAM after an arm/skip phase.
- Replays the burst to the FFT core over a valid/ready stream with a last marker.
- Reports the frame's peak absolute value for downstream block scaling.

Parameters:
- N_LOG2, 10, log2 of frame length (frame = 1024 samples)
- DW, 12, sample width, two's complement
- SKIP, 2, number of qualified samples discarded after start (flushes the upstream 2-stage pipeline)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- data_in  in  DW  sample from the upstream conversion stage, two's complement
- sample_en  in  1  one-cycle strobe; data_in is a valid sample this cycle
- start  in  1  one-cycle pulse; begins a burst, honoured only in IDLE
- abort  in  1  synchronous return to IDLE from any state
- fft_data  out  DW  stream sample
- fft_valid  out  1  stream valid
- fft_ready  in  1  stream ready from the FFT core
- fft_last  out  1  high with the final sample of the frame
- peak_abs  out  DW-1  largest |sample| of the last completed capture, saturating
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the transfer of the last sample

Behaviour:
- Reset values: fft_data=0, fft_valid=0, fft_last=0, peak_abs=0, busy=0, done=0. State=IDLE, all counters 0.
- States: IDLE, ARM, CAPTURE, READOUT.
- IDLE: start=1 goes to ARM and clears skip_cnt. start in any other state is ignored.
- ARM: each sample_en increments skip_cnt. The SKIP-th qualified sample is discarded and the state moves to CAPTURE. If SKIP=0, IDLE goes straight to CAPTURE.
- CAPTURE, on each sample_en:
  - write data_in to RAM[wr_addr], then increment wr_addr;
  - update the running peak.
  - When the sample at wr_addr = 2^N_LOG2-1 is written, move to READOUT, wrap wr_addr to 0, and load peak_abs from the running peak.
  - The running peak is cleared on entry to CAPTURE.
- Peak arithmetic:
  - abs = sample[DW-1] ? (-sample) : sample, computed in DW bits.
  - -2048 (0x800) saturates to 2047 (0x7FF).
  - peak_abs holds its value until the next frame's CAPTURE completes.
- READOUT:
  - The RAM has 1-cycle synchronous read latency.
  - fft_valid first asserts exactly 2 cycles after the READOUT entry edge.
  - A transfer happens when fft_valid && fft_ready.
  - While fft_valid=1 && fft_ready=0, fft_data and fft_last hold stable.
  - With fft_ready held high, one sample transfers per cycle with no bubbles. This needs a prefetch/skid register.
  - Samples are output in capture order, addresses 0..2^N_LOG2-1.
  - fft_last=1 only with address 2^N_LOG2-1.
  - On the last transfer: done pulses, fft_valid drops next cycle, state goes to IDLE.
- sample_en outside ARM/CAPTURE is ignored; no RAM write occurs.
- abort in any state:
  - next state is IDLE; fft_valid, fft_last and busy go low next cycle;
  - counters are cleared;
  - peak_abs keeps its previous completed value;
  - done does not pulse.
- abort and start in the same cycle: abort wins.
- Asynchronous reset mid-burst: immediate return to reset values. RAM contents are undefined and never read before they are rewritten.

Test Plan:
- Reset, then start with SKIP=2. Feed 1026 sample_en strobes with data_in = index mod 2048 (two's complement). Require:
  - capture of values 2..1025, in order;
  - 1024 transfers with fft_ready=1;
  - first fft_valid 2 cycles after READOUT entry;
  - fft_last and done on the 1024th transfer;
  - busy low afterwards.
- Backpressure: drive fft_ready with a pseudo-random pattern of about 50% duty. Require all 1024 samples in order, no duplicates, and fft_data stable across every stalled cycle.
- Peak: a frame containing +1500, -1998 and -2048 (0x800) → peak_abs=2047. A following frame with max |x|=300 → peak_abs=300 after that capture, and 2047 until then.
- abort at capture sample 500 → IDLE next cycle, busy=0, no done, peak_abs unchanged. A new start then captures a full fresh frame correctly.
- Ignored inputs: start pulsed during CAPTURE and READOUT has no effect. sample_en during READOUT does not alter the replayed data. abort+start in the same cycle in IDLE → stays IDLE.
- Assert rst_n low mid-READOUT → all outputs at reset values asynchronously. After release, a full burst completes normally.
